// File: rtl/boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// boot_loader_pkg
// Shared definitions for the IMEM boot loader: FSM state encoding and the
// byte counts of the image framing (header and trailer).
// -----------------------------------------------------------------------------
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    RUN,
    ERR
  } state_t;

  // Image framing: 16-bit little-endian word count, then the words, then one
  // XOR checksum byte.
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

endpackage : boot_loader_pkg

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Assembles little-endian 32-bit words from a byte stream and keeps a running
// XOR of every byte taken since the last clear.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous clear of word, byte counter and checksum
//   take        : a data byte is consumed this cycle
//   byte_data   : the byte being consumed
//   word_next   : the word as it will be once byte_data is shifted in; equals
//                 the complete word when take && last
//   last        : the byte being taken completes the current word
//   csum        : running XOR of all bytes taken since clear
// -----------------------------------------------------------------------------
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic        last,
  output logic [7:0]  csum
);

  logic [31:0] word;
  logic [1:0]  byte_cnt;

  // Bytes enter at the top and move down, so after four bytes the first one
  // sits in [7:0].
  assign word_next = {byte_data, word[31:8]};
  assign last      = (byte_cnt == 2'd3);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
      csum     <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_cnt <= '0;
      csum     <= '0;
    end else if (take) begin
      word     <= word_next;
      byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
      csum     <= csum ^ byte_data;
    end
  end

endmodule : byte_word_packer

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Loads a program image from a byte stream into the instruction memory and
// holds the core in reset until a complete, checksum-valid image is written.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : one-cycle pulse; begins a load from IDLE, RUN or ERR
//   rx_valid     : byte available on rx_data
//   rx_data      : stream byte
//   rx_ready     : loader accepts a byte this cycle
//   imem_we      : IMEM write strobe (one cycle per word)
//   imem_waddr   : IMEM word address, held between writes
//   imem_wdata   : IMEM write word, held between writes
//   core_rst_n   : active-low core reset, released only in RUN
//   busy         : a load session is in progress
//   done         : image loaded and core running
//   err          : session rejected (bad word count or checksum)
// -----------------------------------------------------------------------------
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] DEPTH16 = 16'(IMEM_DEPTH);

  state_t            state, state_d;
  logic              seq_cnt;     // byte index within header / trailer
  logic [15:0]       n_words;
  logic [ADDR_W-1:0] addr;

  logic        take;
  logic [15:0] n_full;
  logic        last_word;
  logic        pk_clear, pk_take, pk_last;
  logic [31:0] pk_word_next;
  logic [7:0]  pk_csum;

  assign take      = rx_valid && rx_ready;
  // Word count as it stands once the current header byte is shifted in.
  assign n_full    = {rx_data, n_words[15:8]};
  assign last_word = (16'(addr) == n_words - 16'd1);
  assign pk_take   = take && (state == DATA);

  byte_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .take      (pk_take),
    .byte_data (rx_data),
    .word_next (pk_word_next),
    .last      (pk_last),
    .csum      (pk_csum)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    pk_clear = 1'b0;
    unique case (state)
      IDLE, RUN, ERR: if (start) state_d = HDR;
      HDR: begin
        if (take && seq_cnt == 1'(HDR_BYTES - 1)) begin
          if (n_full == 16'd0 || n_full > DEPTH16) begin
            state_d = ERR;
          end else begin
            state_d  = DATA;
            pk_clear = 1'b1;
          end
        end
      end
      DATA:  if (take && pk_last) state_d = WRITE;
      WRITE: state_d = last_word ? CSUM : DATA;
      CSUM: begin
        if (take && seq_cnt == 1'(CSUM_BYTES - 1)) begin
          state_d = (rx_data == pk_csum) ? RUN : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      seq_cnt    <= 1'b0;
      n_words    <= '0;
      addr       <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_d;

      if (state != state_d) seq_cnt <= 1'b0;
      else if (take)        seq_cnt <= seq_cnt + 1'b1;

      if (state == HDR && take) n_words <= n_full;

      if (pk_clear)           addr <= '0;
      else if (state == WRITE) addr <= addr + ADDR_W'(1);

      // Outputs are registered from the next state so they line up with the
      // state they describe, with no combinational path to the pins.
      imem_we <= (state_d == WRITE);
      if (state == DATA && state_d == WRITE) begin
        imem_waddr <= addr;
        imem_wdata <= pk_word_next;
      end
      rx_ready   <= (state_d inside {HDR, DATA, CSUM});
      busy       <= (state_d inside {HDR, DATA, WRITE, CSUM});
      done       <= (state_d == RUN);
      core_rst_n <= (state_d == RUN);
      err        <= (state_d == ERR);
    end
  end

endmodule : imem_boot_loader

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed bench for imem_boot_loader: reset state, valid loads, checksum and
// word-count rejection, stalled input stream with ignored start pulses, and
// asynchronous reset in the middle of a session.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] img [4];

  always #5 clk = ~clk;

  imem_boot_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Record every IMEM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_reset_outputs(input string ph);
    check({ph, "_rx_ready"},   rx_ready,   0);
    check({ph, "_imem_we"},    imem_we,    0);
    check({ph, "_imem_waddr"}, imem_waddr, 0);
    check({ph, "_imem_wdata"}, imem_wdata, 0);
    check({ph, "_core_rst_n"}, core_rst_n, 0);
    check({ph, "_busy"},       busy,       0);
    check({ph, "_done"},       done,       0);
    check({ph, "_err"},        err,        0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int budget;
    if (gappy) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'hxx;
        start    = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        start = 1'b0;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 50;
    while (!rx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("rx_ready_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends header, n words from img and the given checksum byte. After each
  // word the write cycle must show imem_we=1 and rx_ready=0.
  task automatic send_image(input int n, input logic [7:0] csum, input bit gappy);
    logic [31:0] w;
    send_byte(8'(n), gappy);
    send_byte(8'(n >> 8), gappy);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gappy);
      check("write_cycle_we", imem_we, 1);
      check("write_cycle_ready", rx_ready, 0);
    end
    check("pre_csum_done", done, 0);
    send_byte(csum, gappy);
  endtask

  task automatic check_writes(input string ph, input int n);
    check({ph, "_write_count"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({ph, "_waddr"}, wr_addr[i], i);
      check({ph, "_wdata"}, wr_data[i], img[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b1;   // held high through reset: must not be accepted
    rx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rx_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("idle_ready", rx_ready, 0);

    // Two-word image: bytes 93 00 50 00 13 01 A0 00, XOR = 0x71.
    img[0] = 32'h0050_0093;
    img[1] = 32'h00A0_0113;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("start_busy", busy, 1);
    check("start_ready", rx_ready, 1);
    send_image(2, 8'h71, 1'b0);
    check("load1_done", done, 1);
    check("load1_core_rst_n", core_rst_n, 1);
    check("load1_busy", busy, 0);
    check("load1_err", err, 0);
    check_writes("load1", 2);

    // Reload from RUN reasserts core reset; wrong checksum rejects the image.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("reload_core_rst_n", core_rst_n, 0);
    check("reload_done", done, 0);
    check("reload_busy", busy, 1);
    send_image(2, 8'h00, 1'b0);
    check("badcsum_err", err, 1);
    check("badcsum_core_rst_n", core_rst_n, 0);
    check("badcsum_done", done, 0);
    check_writes("badcsum", 2);
    pulse_start();
    check("restart_err_cleared", err, 0);
    check("restart_busy", busy, 1);

    // Word count 0x0101 exceeds the 256-word IMEM.
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("oversize_err", err, 1);
    check("oversize_busy", busy, 0);
    check("oversize_writes", wr_addr.size(), 0);
    // N=0 is rejected the same way.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("zero_n_err", err, 1);
    check("zero_n_writes", wr_addr.size(), 0);

    // Four words with a stalling stream and stray start pulses.
    // XOR: (78^56^34^12)=08, (EF^BE^AD^DE)=22, 00s=00, FFs=00 -> 0x2A.
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    img[2] = 32'h0000_0000;
    img[3] = 32'hFFFF_FFFF;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_image(4, 8'h2A, 1'b1);
    check("gappy_done", done, 1);
    check("gappy_core_rst_n", core_rst_n, 1);
    check("gappy_err", err, 0);
    check_writes("gappy", 4);

    // Asynchronous reset while the third word is arriving.
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) send_byte(img[i][8*j +: 8], 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_busy", busy, 0);

    img[0] = 32'h0050_0093;
    img[1] = 32'h00A0_0113;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_image(2, 8'h71, 1'b0);
    check("recover_done", done, 1);
    check("recover_core_rst_n", core_rst_n, 1);
    check_writes("recover", 2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_imem_boot_loader
